// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU arbiter and its ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SH_W   = 5;

  localparam logic [OP_W-1:0] OP_LRS  = 4'b0000;
  localparam logic [OP_W-1:0] OP_LLS  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ARS  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ALS  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0101;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1100;

  // Bit n set when opcode n belongs to the group.
  localparam logic [15:0] OVF_OP_MASK   = 16'h007F;
  localparam logic [15:0] LEGAL_OP_MASK = 16'h1F7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [OP_W-1:0]   alu_op;
  } alu_req_t;

  function automatic logic is_ovf_op(input logic [OP_W-1:0] op);
    return OVF_OP_MASK[op];
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return LEGAL_OP_MASK[op];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: logic, add/sub/mul and shifts with signed overflow flag.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c,
  output logic              ovf_c
);

  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] wide;

  always_comb begin
    sh       = op2[SH_W-1:0];
    sum      = op1 + op2;
    diff     = op1 - op2;
    prod     = $signed({{DATA_W{op1[DATA_W-1]}}, op1}) * $signed({{DATA_W{op2[DATA_W-1]}}, op2});
    wide     = {{DATA_W{1'b0}}, op1} << sh;
    result_c = '0;
    ovf_c    = 1'b0;
    case (alu_op)
      OP_AND:  result_c = op1 & op2;
      OP_OR:   result_c = op1 | op2;
      OP_NOR:  result_c = ~(op1 | op2);
      OP_NAND: result_c = ~(op1 & op2);
      OP_XOR:  result_c = op1 ^ op2;
      OP_ADD: begin
        result_c = sum;
        ovf_c    = (op1[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != op1[DATA_W-1]);
      end
      OP_SUB: begin
        result_c = diff;
        ovf_c    = (op1[DATA_W-1] != op2[DATA_W-1]) && (diff[DATA_W-1] != op1[DATA_W-1]);
      end
      OP_MUL: begin
        // Overflow when the 64-bit product is not a sign extension of its low word.
        result_c = prod[DATA_W-1:0];
        ovf_c    = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
      end
      OP_LRS:  result_c = op1 >> sh;
      OP_ARS:  result_c = DATA_W'($signed(op1) >>> sh);
      OP_LLS: begin
        result_c = wide[DATA_W-1:0];
        ovf_c    = |wide[2*DATA_W-1:DATA_W];
      end
      OP_ALS: begin
        result_c = wide[DATA_W-1:0];
        ovf_c    = (DATA_W'($signed(wide[DATA_W-1:0]) >>> sh) != op1);
      end
      default: result_c = '0;
    endcase
    zero_c = (result_c == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters; one operation in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_alu_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_alu_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              busy
);

  state_t            state;
  alu_req_t          req_q;
  logic              gid;
  logic              last;
  logic              grant_c;
  logic              idle_c;
  logic              hs_c;
  logic              legal_c;
  alu_req_t          req_sel_c;
  logic [DATA_W-1:0] alu_result_c;
  logic              alu_zero_c;
  logic              alu_ovf_c;

  // Grant: lone valid wins, a tie goes to the requester not served last.
  always_comb begin
    grant_c    = (req0_valid && req1_valid) ? ~last : req1_valid;
    idle_c     = resetn && (state == ST_IDLE);
    req0_ready = idle_c && req0_valid && !grant_c;
    req1_ready = idle_c && req1_valid && grant_c;
    hs_c       = req0_ready || req1_ready;
    req_sel_c  = grant_c ? alu_req_t'({req1_op1, req1_op2, req1_alu_op})
                         : alu_req_t'({req0_op1, req0_op2, req0_alu_op});
    legal_c    = is_legal_op(req_q.alu_op);
  end

  alu_arbiter_alu u_alu (
    .op1      (req_q.op1),
    .op2      (req_q.op2),
    .alu_op   (req_q.alu_op),
    .result_c (alu_result_c),
    .zero_c   (alu_zero_c),
    .ovf_c    (alu_ovf_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      gid        <= 1'b0;
      last       <= ~1'(RR_INIT);
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs_c) begin
            req_q <= req_sel_c;
            gid   <= grant_c;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal opcodes report a clean zero result with error set.
          rsp_result <= legal_c ? alu_result_c : '0;
          rsp_zero   <= legal_c ? alu_zero_c : 1'b1;
          rsp_ovf    <= alu_ovf_c && is_ovf_op(req_q.alu_op);
          rsp_err    <= !legal_c;
          rsp0_valid <= !gid;
          rsp1_valid <= gid;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last       <= gid;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [3:0] C_LRS = 4'b0000, C_LLS = 4'b0001, C_ARS = 4'b0010, C_ALS = 4'b0011;
  localparam logic [3:0] C_ADD = 4'b0100, C_SUB = 4'b0101, C_MUL = 4'b0110;
  localparam logic [3:0] C_AND = 4'b1000, C_OR = 4'b1001, C_NOR = 4'b1010, C_NAND = 4'b1011;
  localparam logic [3:0] C_XOR = 4'b1100;

  logic        clk, resetn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_alu_op, req1_alu_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err, busy;

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } txn_t;

  txn_t        q0[$], q1[$];
  bit          grants[$];
  int          n_tests, n_fail, cyc, hold0, m_hs;
  bit          rand_valid, rand_rready;
  bit          m_busy, m_last, m_id, hs_pend, hs_id, rs_pend;
  logic [31:0] e_res;
  bit          e_zero, e_ovf, e_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit fits32(input longint v);
    return v == longint'(int'(v));
  endfunction

  // Expected response from the opcode definitions using wide integer arithmetic.
  function automatic void model(input txn_t t, output logic [31:0] r, output bit z, output bit o,
                                output bit e);
    longint la, lb, w;
    int     sh;
    la = longint'($signed(t.a));
    lb = longint'($signed(t.b));
    sh = int'(t.b[4:0]);
    r = '0; o = 1'b0; e = 1'b0;
    case (t.op)
      C_AND:  r = t.a & t.b;
      C_OR:   r = t.a | t.b;
      C_NOR:  r = ~(t.a | t.b);
      C_NAND: r = ~(t.a & t.b);
      C_XOR:  r = t.a ^ t.b;
      C_ADD:  begin w = la + lb; r = 32'(w); o = !fits32(w); end
      C_SUB:  begin w = la - lb; r = 32'(w); o = !fits32(w); end
      C_MUL:  begin w = la * lb; r = 32'(w); o = !fits32(w); end
      C_LRS:  r = t.a >> sh;
      C_ARS:  r = 32'($signed(t.a) >>> sh);
      C_LLS:  begin w = longint'({32'd0, t.a}) << sh; r = 32'(w); o = (w >> 32) != 0; end
      C_ALS:  begin w = la * (longint'(1) << sh); r = 32'(w); o = !fits32(w); end
      default: e = 1'b1;
    endcase
    z = (r == 32'd0);
  endfunction

  function automatic logic [63:0] gbits();
    logic [63:0] v;
    v = '0;
    foreach (grants[i]) if (i < 64) v[i] = grants[i];
    return v;
  endfunction

  task automatic push(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    txn_t t;
    t.a = a; t.b = b; t.op = op;
    if (id) q1.push_back(t);
    else    q0.push_back(t);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic reset_model();
    q0.delete(); q1.delete(); grants.delete();
    m_busy = 0; m_last = 1; m_id = 0; hs_pend = 0; rs_pend = 0; hold0 = 0;
  endtask

  // One clock of stimulus and checking; entered and left 1 time unit after a rising edge.
  task automatic cycle();
    bit v0, v1, r0, r1, ev;
    txn_t t;
    if (hs_pend) begin m_busy = 1; m_id = hs_id; hs_pend = 0; end
    if (rs_pend) begin m_busy = 0; m_last = m_id; rs_pend = 0; end
    ev = m_busy && (cyc >= m_hs + 2);
    check("busy", 64'(busy), 64'(m_busy));
    check("rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, ev ? (m_id ? 64'd2 : 64'd1) : 64'd0);
    if (ev)
      check("rsp_data", {29'd0, rsp_err, rsp_ovf, rsp_zero, rsp_result},
            {29'd0, e_err, e_ovf, e_zero, e_res});
    v0 = (q0.size() != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    v1 = (q1.size() != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    req0_valid = v0;
    req1_valid = v1;
    if (q0.size() != 0) {req0_op1, req0_op2, req0_alu_op} = {q0[0].a, q0[0].b, q0[0].op};
    else                {req0_op1, req0_op2, req0_alu_op} = {$urandom, $urandom, 4'($urandom)};
    if (q1.size() != 0) {req1_op1, req1_op2, req1_alu_op} = {q1[0].a, q1[0].b, q1[0].op};
    else                {req1_op1, req1_op2, req1_alu_op} = {$urandom, $urandom, 4'($urandom)};
    if (hold0 > 0 && ev && !m_id) begin
      rsp0_ready = 1'b0;
      hold0--;
    end else begin
      rsp0_ready = rand_rready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rsp1_ready = rand_rready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    r0 = 0; r1 = 0;
    if (!m_busy) begin
      if (v0 && v1) begin r1 = !m_last; r0 = m_last; end
      else begin r0 = v0; r1 = v1; end
    end
    check("req_ready", {62'd0, req1_ready, req0_ready}, {62'd0, r1, r0});
    if (r0 || r1) begin
      hs_pend = 1; hs_id = r1; m_hs = cyc;
      grants.push_back(r1);
      if (r1) begin t = q1.pop_front(); end
      else    begin t = q0.pop_front(); end
      model(t, e_res, e_zero, e_ovf, e_err);
    end
    if (ev && (m_id ? rsp1_ready : rsp0_ready)) rs_pend = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() != 0 || m_busy || hs_pend || rs_pend) && n < budget) begin
      cycle();
      n++;
    end
    check("drain", 64'(q0.size() + q1.size() + int'(m_busy)), 64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_model();
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rand_valid = 0; rand_rready = 0;
    resetn = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op1 = '0; req0_op2 = '0; req0_alu_op = '0;
    req1_op1 = '0; req1_op2 = '0; req1_alu_op = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("reset_flags", {56'd0, busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready,
                          rsp_err, rsp_ovf, rsp_zero}, 64'd0);
    check("reset_result", 64'(rsp_result), 64'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;

    // Tie straight out of reset: requester 0 first.
    push(0, 32'd5, 32'd5, C_SUB);
    push(1, 32'h0001_0000, 32'h0001_0000, C_MUL);
    run(50);
    check("tie_cnt", 64'(grants.size()), 64'd2);
    check("tie_order", gbits(), 64'b10);

    grants.delete();
    push(0, 32'h7FFF_FFFF, 32'd1, C_ADD);
    run(50);
    check("add_grant", gbits(), 64'b0);

    // Continuous ties alternate starting from requester 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 15)));
      push(1, rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 15)));
    end
    run(100);
    check("rr_cnt", 64'(grants.size()), 64'd6);
    check("rr_order", gbits(), 64'b101010);

    push(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, C_ADD);
    push(1, 32'hFFFF_0000, 32'h0000_FFFF, C_XOR);
    push(1, 32'h1234_5678, 32'h0000_5678, 4'b1111);
    push(1, 32'h0000_0001, 32'h0000_0001, 4'b0111);
    push(1, 32'h4000_0000, 32'd1, C_ALS);
    push(1, 32'h8000_0000, 32'd31, C_ARS);
    run(100);

    // Back-pressure on requester 0 while requester 1 waits.
    do_reset();
    hold0 = 10;
    push(0, 32'd3, 32'd4, C_MUL);
    push(1, 32'd9, 32'd2, C_LLS);
    run(100);
    check("bp_order", gbits(), 64'b10);
    check("bp_hold_used", 64'(hold0), 64'd0);

    // Asynchronous reset during EXEC.
    grants.delete();
    push(0, 32'd123, 32'd456, C_ADD);
    cycle();
    check("mid_busy", 64'(busy), 64'd1);
    req0_valid = 1; req1_valid = 1;
    #2 resetn = 1'b0;
    #1;
    check("rst_flags", {56'd0, busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready,
                        rsp_err, rsp_ovf, rsp_zero}, 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    reset_model();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    push(0, 32'd7, 32'd8, C_OR);
    push(1, 32'hFFFF_FFFF, 32'd1, C_ADD);
    run(50);
    check("post_rst_order", gbits(), 64'b10);

    // Random traffic with random valid gaps and response back-pressure.
    rand_valid = 1; rand_rready = 1;
    for (int i = 0; i < 200; i++)
      push(1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 15)));
    run(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
